// File: rtl/display_scan_ctrl_if.sv
// Display-side bundle for the scan controller: scan inputs from the host,
// and decoder/anode/status outputs back to the board.
interface display_scan_ctrl_if;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic        lz_en;
   logic [3:0]  dec_in;
   logic [3:0]  an;
   logic        dp_n;
   logic        frame_tick;
   logic        bcd_err;

   modport master (
      output enable, digits, dp_mask, lz_en,
      input  dec_in, an, dp_n, frame_tick, bcd_err
   );

   modport slave (
      input  enable, digits, dp_mask, lz_en,
      output dec_in, an, dp_n, frame_tick, bcd_err
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot blanking,
// leading-zero suppression and frame-coherent input capture. All outputs registered.
module display_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int NUM_DIGITS   = 4
) (
   input logic                clk,
   input logic                reset,
   display_scan_ctrl_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    slot;
   logic [15:0]   sh_dig;
   logic [3:0]    sh_dp;

   logic          slot_end;
   logic          last_slot;
   logic          capture;
   logic          bad;
   logic [1:0]    slot_nxt;
   logic [15:0]   dig_nxt;
   logic [3:0]    dp_nxt;
   logic [3:0]    lz_blank;

   always_comb begin
      slot_end  = (cnt == CW'(REFRESH_DIV - 1));
      last_slot = (slot == 2'(NUM_DIGITS - 1));
      slot_nxt  = slot;
      if (state != OFF && slot_end)
         slot_nxt = last_slot ? 2'd0 : slot + 2'd1;
      // Shadow reloads only at a frame boundary so a frame never mixes inputs
      capture = (state == OFF) || (slot_end && last_slot);
      dig_nxt = capture ? bus.digits  : sh_dig;
      dp_nxt  = capture ? bus.dp_mask : sh_dp;
   end

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < 4; i++)
         if (sh_dig[i*4 +: 4] > 4'd9) bad = 1'b1;
   end

   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = bus.lz_en && (sh_dig[15:12] == 4'h0);
      lz_blank[2] = lz_blank[3] && (sh_dig[11:8] == 4'h0);
      lz_blank[1] = lz_blank[2] && (sh_dig[7:4] == 4'h0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= OFF;
         cnt            <= '0;
         slot           <= '0;
         sh_dig         <= '0;
         sh_dp          <= '0;
         bus.dec_in     <= 4'h0;
         bus.an         <= 4'hF;
         bus.dp_n       <= 1'b1;
         bus.frame_tick <= 1'b0;
         bus.bcd_err    <= 1'b0;
      end else if (!bus.enable) begin
         state          <= OFF;
         cnt            <= '0;
         slot           <= '0;
         bus.an         <= 4'hF;
         bus.dp_n       <= 1'b1;
         bus.frame_tick <= 1'b0;
         bus.bcd_err    <= 1'b0;
      end else begin
         sh_dig         <= dig_nxt;
         sh_dp          <= dp_nxt;
         slot           <= slot_nxt;
         bus.bcd_err    <= (state == BLANK) && (cnt == '0) && (slot == 2'd0) && bad;
         bus.frame_tick <= (state != OFF) && last_slot && (cnt == CW'(REFRESH_DIV - 2));
         if (state == OFF || slot_end) begin
            // New slot opens dark, so the decoder input only moves while all anodes are off
            state      <= BLANK;
            cnt        <= '0;
            bus.dec_in <= dig_nxt[{slot_nxt, 2'b00} +: 4];
            bus.an     <= 4'hF;
            bus.dp_n   <= 1'b1;
         end else begin
            cnt <= cnt + CW'(1);
            if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) begin
               state    <= SHOW;
               bus.an   <= lz_blank[slot] ? 4'hF : ~(4'b0001 << slot);
               bus.dp_n <= ~(sh_dp[slot] & ~lz_blank[slot]);
            end
         end
      end
   end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameters SHALL be exactly these three.
- REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz).
- BLANK_CYCLES, default 1000, cycles at the start of each slot during which all anodes are off.
- NUM_DIGITS, default 4, number of multiplexed digits; fixed at 4 in this revision.

REQ-002 Legal parameter range SHALL be REFRESH_DIV >= 2 and 1 <= BLANK_CYCLES < REFRESH_DIV; other values are unsupported.

REQ-003 The clock domain SHALL be a single clock, clk; reset is synchronous and active-high, named reset.

REQ-004 Ports SHALL be exactly these, listed as name, direction, width, meaning.
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, scan enable; low forces the display dark.
- digits, in, 16, BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3.
- dp_mask, in, 4, decimal-point request per digit, active-high.
- lz_en, in, 1, leading-zero blanking enable.
- dec_in, out, 4, BCD nibble driven to the shared 7-segment decoder input.
- an, out, 4, digit anodes, active-low; bit k selects digit k.
- dp_n, out, 1, decimal point, active-low.
- frame_tick, out, 1, one-cycle pulse on the last cycle of slot 3.
- bcd_err, out, 1, one-cycle pulse when a captured digit is greater than 9.

Function
REQ-005 The block SHALL time-share one decoder among 4 digits, one slot per digit, in the order 0,1,2,3,0,... with wrap-around after slot 3.

REQ-006 A slot counter SHALL count 0..REFRESH_DIV-1; on reaching REFRESH_DIV-1 it wraps to 0 and the slot index advances.

REQ-007 The FSM SHALL have states OFF, BLANK and SHOW.
- OFF -> BLANK when enable=1.
- BLANK -> SHOW when the counter equals BLANK_CYCLES-1.
- SHOW -> BLANK at the slot end.
- Any state -> OFF when enable=0.

REQ-008 In OFF and BLANK, an SHALL be 4'b1111 and dp_n SHALL be 1.

REQ-009 In SHOW, an SHALL be all-ones except bit[slot]=0, unless that digit is leading-zero blanked.

REQ-010 dec_in SHALL be updated to the shadow nibble of the current slot on the first cycle of that slot (counter=0, inside BLANK) and held constant for the whole slot.

REQ-011 The shadow register SHALL capture digits and dp_mask on counter=0 of slot 0 and on the OFF->BLANK transition, so that a frame never mixes two input values.

REQ-012 bcd_err SHALL pulse for one cycle, on the cycle after capture, if any captured nibble is greater than 9; that nibble is still passed to dec_in unchanged, and the decoder shows its invalid pattern.

REQ-013 When lz_en=1, digit k (k=1..3) SHALL be blanked (an stays 1111 for its whole SHOW phase) if shadow digits k..3 are all zero; digit0 is never blanked.

REQ-014 dp_n SHALL be 0 during SHOW of slot k if and only if shadow dp_mask[k]=1 and digit k is not blanked.

REQ-015 frame_tick SHALL be 1 only on the cycle where slot=3 and counter=REFRESH_DIV-1, and only while enable=1.

REQ-016 When enable falls, the next cycle SHALL have an=1111 and dp_n=1, with counter=0 and slot=0 held.

REQ-017 When enable rises, counting SHALL start from slot 0, counter 0, with a fresh capture.

REQ-018 Changes on digits, dp_mask or lz_en in mid-frame SHALL NOT affect outputs until the next capture; lz_en is sampled combinationally against the shadow digits.

REQ-019 No two anodes SHALL ever be low in the same cycle, and an SHALL always be 1111 on the cycle in which dec_in changes.

Reset
REQ-020 While reset=1, the block SHALL enter OFF.
- an=4'b1111, dp_n=1, dec_in=4'h0, frame_tick=0, bcd_err=0.
- Counter=0, slot=0, shadow registers=0.

REQ-021 On the first cycle after reset=0 with enable=1, the block SHALL behave as an enable rise.

REQ-022 Reset asserted mid-slot SHALL take effect at the next clock edge and override enable.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-023 The bench SHALL cover these scenarios.
- digits=16'h1234, enable=1, lz_en=0 -> per slot: 2 cycles an=1111, then 6 cycles an=1110/1101/1011/0111 with dec_in=4,3,2,1; frame_tick every 32 cycles.
- digits=16'h0005, lz_en=1 -> slots 1..3 keep an=1111 throughout; slot0 shows dec_in=5 with an=1110.
- digits changed 16'h1234->16'h5678 during slot 1 -> remaining slots still show 3,2,1; the next frame shows 8,7,6,5.
- digits=16'h00A0 -> bcd_err pulses once per frame capture; dec_in=4'hA during slot 1.
- enable dropped in SHOW of slot 2 -> an=1111 the next cycle; re-enable -> slot 0 begins with 2 blank cycles.
- reset pulsed during SHOW with dp_mask=4'hF -> next cycle an=1111, dp_n=1, dec_in=0; a checker asserts at most one an bit is low at any time.
